// File: rtl/conv1d_sequencer.sv
// Controller for the conv1d buffers: one start computes every output position of a 1-D convolution.
// Optional output activation clamp: define CONV1D_SEQ_CLAMP_EN.
module conv1d_sequencer #(
  parameter int unsigned KERNEL_LENGTH = 8,
  parameter int unsigned MAX_WIDTH     = 1024,
  parameter int unsigned MAX_CHANNELS  = 128,
  parameter int unsigned IN_AW         = 17,
  parameter int unsigned K_AW          = 10,
  parameter int unsigned OUT_AW        = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [31:0]              cfg_width,
  input  logic [31:0]              cfg_depth,
  input  logic signed [31:0]       cfg_in_off,
  input  logic signed [31:0]       cfg_bias,
`ifdef CONV1D_SEQ_CLAMP_EN
  input  logic signed [31:0]       cfg_act_min,
  input  logic signed [31:0]       cfg_act_max,
`endif
  output logic [IN_AW-1:0]         in_rd_addr,
  input  logic signed [7:0]        in_rd_data,
  output logic [K_AW-1:0]          k_rd_addr,
  input  logic signed [7:0]        k_rd_data,
  output logic                     out_wr_en,
  output logic [OUT_AW-1:0]        out_wr_addr,
  output logic signed [31:0]       out_wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int unsigned PAD = KERNEL_LENGTH / 2 - 1;
  localparam int unsigned FW  = $clog2(KERNEL_LENGTH);
  localparam int unsigned XW  = $clog2(MAX_WIDTH) + 2;
  localparam int unsigned DW  = $clog2(MAX_CHANNELS) + 1;
  localparam int unsigned BW  = IN_AW + 3;
  localparam int unsigned KBW = K_AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t state_q, st_d;

  logic [XW-1:0]        width_q;
  logic [DW-1:0]        depth_q;
  logic signed [31:0]   in_off_q, bias_q;
`ifdef CONV1D_SEQ_CLAMP_EN
  logic signed [31:0]   act_min_q, act_max_q;
`endif

  logic [OUT_AW-1:0]    out_x_q, out_x_d;
  logic [FW-1:0]        f_q, f_d;
  logic [DW-1:0]        ch_q, ch_d;
  logic [XW-1:0]        in_x_q, in_x_d;
  logic [BW-1:0]        row_base_q, row_base_d, in_base_q, in_base_d;
  logic [KBW-1:0]       k_base_q, k_base_d;
  logic signed [31:0]   acc_q, acc_d;
  logic                 mac_v_q, mac_v_d;

  logic [IN_AW-1:0]     in_addr_d;
  logic [K_AW-1:0]      k_addr_d;
  logic                 wr_en_d, busy_d, done_d, err_d;
  logic [OUT_AW-1:0]    wr_addr_d;
  logic signed [31:0]   wr_data_d;

  logic                 accept, cfg_bad, tap_valid, last_ch, last_tap, last_out;
  logic [BW-1:0]        dep, new_dep;
  logic signed [31:0]   in_ext, k_ext, prod, acc_mac, wsum, result;

  assign accept   = (state_q == S_IDLE) && start && !abort;
  assign cfg_bad  = (cfg_width == 32'd0) || (cfg_width > MAX_WIDTH) ||
                    (cfg_depth == 32'd0) || (cfg_depth > MAX_CHANNELS);
  assign dep      = BW'(depth_q);
  assign new_dep  = BW'(DW'(cfg_depth));
  // A tap contributes only when its input position lies inside [0, width).
  assign tap_valid = !in_x_q[XW-1] && ($unsigned(in_x_q) < width_q);
  assign last_ch   = (ch_q == depth_q - DW'(1));
  assign last_tap  = (f_q == FW'(KERNEL_LENGTH - 1));
  assign last_out  = (XW'(out_x_q) == width_q - XW'(1));

  // RAM data arrives the cycle after the address, so the MAC trails issue by one.
  assign in_ext  = 32'(in_rd_data);
  assign k_ext   = 32'(k_rd_data);
  assign prod    = k_ext * (in_ext + in_off_q);
  assign acc_mac = mac_v_q ? acc_q + prod : acc_q;
  assign wsum    = acc_mac + bias_q;

`ifdef CONV1D_SEQ_CLAMP_EN
  always_comb begin
    result = wsum;
    if (result < act_min_q) result = act_min_q;
    if (result > act_max_q) result = act_max_q;
  end
`else
  assign result = wsum;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= st_d;
  end

  always_comb begin
    st_d       = state_q;
    out_x_d    = out_x_q;
    f_d        = f_q;
    ch_d       = ch_q;
    in_x_d     = in_x_q;
    row_base_d = row_base_q;
    in_base_d  = in_base_q;
    k_base_d   = k_base_q;
    acc_d      = acc_q;
    mac_v_d    = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    wr_en_d    = 1'b0;
    wr_addr_d  = out_wr_addr;
    wr_data_d  = out_wr_data;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cfg_bad) begin
            st_d   = S_DONE;
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            st_d       = S_RUN;
            busy_d     = 1'b1;
            out_x_d    = '0;
            f_d        = '0;
            ch_d       = '0;
            in_x_d     = XW'(0) - XW'(PAD);
            row_base_d = BW'(0) - BW'(PAD) * new_dep;
            in_base_d  = row_base_d;
            k_base_d   = '0;
            acc_d      = '0;
          end
        end
      end
      S_RUN: begin
        busy_d  = 1'b1;
        acc_d   = acc_mac;
        mac_v_d = tap_valid;
        if (!tap_valid || last_ch) begin
          if (last_tap) begin
            st_d = S_DRAIN;
          end else begin
            f_d       = f_q + FW'(1);
            ch_d      = '0;
            in_x_d    = in_x_q + XW'(1);
            in_base_d = in_base_q + dep;
            k_base_d  = k_base_q + KBW'(depth_q);
          end
        end else begin
          ch_d = ch_q + DW'(1);
        end
      end
      S_DRAIN: begin
        st_d      = S_WRITE;
        busy_d    = 1'b1;
        acc_d     = acc_mac;
        wr_en_d   = 1'b1;
        wr_addr_d = out_x_q;
        wr_data_d = result;
      end
      S_WRITE: begin
        if (last_out) begin
          st_d   = S_DONE;
          done_d = 1'b1;
        end else begin
          st_d       = S_RUN;
          busy_d     = 1'b1;
          out_x_d    = out_x_q + OUT_AW'(1);
          f_d        = '0;
          ch_d       = '0;
          in_x_d     = XW'(out_x_q) - XW'(PAD - 1);
          row_base_d = row_base_q + dep;
          in_base_d  = row_base_d;
          k_base_d   = '0;
          acc_d      = '0;
        end
      end
      S_DONE:  st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
    // Abort drops the run immediately without reporting completion.
    if (abort && (state_q != S_IDLE)) begin
      st_d    = S_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      wr_en_d = 1'b0;
      mac_v_d = 1'b0;
    end
    in_addr_d = IN_AW'(in_base_d + BW'(ch_d));
    k_addr_d  = K_AW'(k_base_d + KBW'(ch_d));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      width_q     <= '0;
      depth_q     <= '0;
      in_off_q    <= '0;
      bias_q      <= '0;
`ifdef CONV1D_SEQ_CLAMP_EN
      act_min_q   <= '0;
      act_max_q   <= '0;
`endif
      out_x_q     <= '0;
      f_q         <= '0;
      ch_q        <= '0;
      in_x_q      <= '0;
      row_base_q  <= '0;
      in_base_q   <= '0;
      k_base_q    <= '0;
      acc_q       <= '0;
      mac_v_q     <= 1'b0;
      in_rd_addr  <= '0;
      k_rd_addr   <= '0;
      out_wr_en   <= 1'b0;
      out_wr_addr <= '0;
      out_wr_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      if (accept) begin
        width_q   <= XW'(cfg_width);
        depth_q   <= DW'(cfg_depth);
        in_off_q  <= cfg_in_off;
        bias_q    <= cfg_bias;
`ifdef CONV1D_SEQ_CLAMP_EN
        act_min_q <= cfg_act_min;
        act_max_q <= cfg_act_max;
`endif
      end
      out_x_q     <= out_x_d;
      f_q         <= f_d;
      ch_q        <= ch_d;
      in_x_q      <= in_x_d;
      row_base_q  <= row_base_d;
      in_base_q   <= in_base_d;
      k_base_q    <= k_base_d;
      acc_q       <= acc_d;
      mac_v_q     <= mac_v_d;
      in_rd_addr  <= in_addr_d;
      k_rd_addr   <= k_addr_d;
      out_wr_en   <= wr_en_d;
      out_wr_addr <= wr_addr_d;
      out_wr_data <= wr_data_d;
      busy        <= busy_d;
      done        <= done_d;
      err         <= err_d;
    end
  end

endmodule

// File: tb/tb_conv1d_sequencer.sv
// Directed bench for conv1d_sequencer with RAM models and a write scoreboard.
module tb_conv1d_sequencer;

  logic               clk = 1'b0;
  logic               reset, start, abort;
  logic [31:0]        cfg_width, cfg_depth;
  logic signed [31:0] cfg_in_off, cfg_bias;
`ifdef CONV1D_SEQ_CLAMP_EN
  logic signed [31:0] cfg_act_min, cfg_act_max;
`endif
  logic [16:0]        in_rd_addr;
  logic signed [7:0]  in_rd_data;
  logic [9:0]         k_rd_addr;
  logic signed [7:0]  k_rd_data;
  logic               out_wr_en;
  logic [9:0]         out_wr_addr;
  logic signed [31:0] out_wr_data;
  logic               busy, done, err;

  always #5 clk = ~clk;

  conv1d_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_width(cfg_width), .cfg_depth(cfg_depth),
    .cfg_in_off(cfg_in_off), .cfg_bias(cfg_bias),
`ifdef CONV1D_SEQ_CLAMP_EN
    .cfg_act_min(cfg_act_min), .cfg_act_max(cfg_act_max),
`endif
    .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
    .k_rd_addr(k_rd_addr), .k_rd_data(k_rd_data),
    .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data),
    .busy(busy), .done(done), .err(err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  logic signed [7:0] in_mem [256];
  logic signed [7:0] k_mem  [256];

  // Synchronous-read RAM models: data follows the address by one cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    in_rd_data <= (in_rd_addr < 17'd256) ? in_mem[in_rd_addr[7:0]] : 8'sd0;
    k_rd_data  <= (k_rd_addr < 10'd256)  ? k_mem[k_rd_addr[7:0]]   : 8'sd0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_wr_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(out_wr_en), 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(out_wr_addr), 32'(e.addr));
        chk("wr_data", out_wr_data, e.data);
      end
    end
  end

  function automatic int model_out(int x, int w, int d, int off, int bias);
    int acc = 0;
    for (int f = 0; f < 8; f++) begin
      int ix = x - 3 + f;
      if (ix >= 0 && ix < w)
        for (int c = 0; c < d; c++)
          acc += int'(k_mem[f * d + c]) * (int'(in_mem[ix * d + c]) + off);
    end
    return acc + bias;
  endfunction

  function automatic int model_done_cycle(int w, int d);
    int total = 0;
    for (int x = 0; x < w; x++) begin
      for (int f = 0; f < 8; f++) begin
        int ix = x - 3 + f;
        total += (ix >= 0 && ix < w) ? d : 1;
      end
      total += 2;
    end
    return total + 1;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      in_mem[i] = 8'sd0;
      k_mem[i]  = 8'sd0;
    end
  endtask

  task automatic load_test1();
    clear_mem();
    for (int i = 0; i < 4; i++) in_mem[i] = 8'(i + 1);
    for (int i = 0; i < 8; i++) k_mem[i] = 8'sd1;
    cfg_width = 32'd4; cfg_depth = 32'd1; cfg_in_off = 0; cfg_bias = 0;
  endtask

  task automatic push_all(int w, int d);
    for (int x = 0; x < w; x++) begin
      wr_t e;
      e.addr = 10'(x);
      e.data = model_out(x, w, d, cfg_in_off, cfg_bias);
      exp_q.push_back(e);
    end
  endtask

  task automatic launch(input logic exp_busy);
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("busy_cycle1", 32'(busy), 32'(exp_busy));
  endtask

  task automatic wait_to(int n);
    for (int i = 0; i < 4000 && (cyc - t0) < n; i++) @(negedge clk);
  endtask

  task automatic wait_done(int exp_cycle, logic exp_err);
    for (int i = 0; i < 4000 && !done; i++) @(negedge clk);
    chk("done_cycle", 32'(cyc - t0), 32'(exp_cycle));
    chk("err", 32'(err), 32'(exp_err));
    chk("busy_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_pulse_width", 32'(done), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_wr_en"}, 32'(out_wr_en), 32'd0);
    chk({tag, "_in_addr"}, 32'(in_rd_addr), 32'd0);
    chk({tag, "_k_addr"}, 32'(k_rd_addr), 32'd0);
    chk({tag, "_wr_addr"}, 32'(out_wr_addr), 32'd0);
    chk({tag, "_wr_data"}, out_wr_data, 32'd0);
  endtask

  initial begin
    int dn;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_width = 0; cfg_depth = 0; cfg_in_off = 0; cfg_bias = 0;
`ifdef CONV1D_SEQ_CLAMP_EN
    cfg_act_min = 32'sh8000_0000; cfg_act_max = 32'sh7fff_ffff;
`endif
    clear_mem();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;

    // Test 1: box filter over [1,2,3,4].
    load_test1();
    push_all(4, 1);
    launch(1'b1);
    wait_done(41, 1'b0);

    // Test 2: offset input and negative bias.
    clear_mem();
    in_mem[0] = -8'sd128; in_mem[1] = 8'sd5;
    k_mem[6] = 8'sd2; k_mem[7] = 8'sd3;
    cfg_width = 32'd1; cfg_depth = 32'd2; cfg_in_off = 128; cfg_bias = -7;
    exp_q.push_back({10'd0, 32'sd392});
    launch(1'b1);
    wait_done(model_done_cycle(1, 2), 1'b0);

`ifdef CONV1D_SEQ_CLAMP_EN
    // Test 3: same run with the activation clamp.
    cfg_act_min = -128; cfg_act_max = 127;
    exp_q.push_back({10'd0, 32'sd127});
    launch(1'b1);
    wait_done(model_done_cycle(1, 2), 1'b0);
    cfg_act_min = 32'sh8000_0000; cfg_act_max = 32'sh7fff_ffff;
`endif

    // Multi-channel run with mixed-sign data checked against the reference model.
    clear_mem();
    for (int i = 0; i < 9; i++)  in_mem[i] = 8'(i * 29 - 100);
    for (int i = 0; i < 24; i++) k_mem[i]  = 8'(i * 13 - 77);
    cfg_width = 32'd3; cfg_depth = 32'd3; cfg_in_off = -3; cfg_bias = 100;
    push_all(3, 3);
    launch(1'b1);
    wait_done(model_done_cycle(3, 3), 1'b0);

    // Test 4: illegal configurations.
    cfg_width = 32'd4; cfg_depth = 32'd0;
    launch(1'b0);
    wait_done(1, 1'b1);
    cfg_width = 32'd1025; cfg_depth = 32'd1;
    launch(1'b0);
    wait_done(1, 1'b1);

    // Test 5a: start pulsed again mid-run and cfg changed after launch.
    load_test1();
    push_all(4, 1);
    launch(1'b1);
    cfg_width = 32'd2; cfg_bias = 55;
    wait_to(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(41, 1'b0);

    // Test 5b: abort during cycle 5.
    load_test1();
    launch(1'b1);
    wait_to(5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    dn = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", 32'(dn), 32'd0);

    // Simultaneous start and abort in IDLE launches nothing.
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'd0);

    // Test 6: reset at cycle 12 after the first write.
    load_test1();
    exp_q.push_back({10'd0, 32'sd10});
    launch(1'b1);
    wait_to(12);
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("midrun_reset");
    reset = 1'b0;
    chk("midrun_sb_empty", 32'(exp_q.size()), 32'd0);
    load_test1();
    push_all(4, 1);
    launch(1'b1);
    wait_done(41, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
